// File: rtl/vregfile_vector_mp_if.sv
// Bundles the data-side signals of vregfile_vector_mp into one interface.
// Slot order for read signals: read port p, bank k lives in slot p*NUMBANKS+k.
// There is no valid/ready handshake here. Every enabled read and write
// is accepted on the rising edge where it is presented. The register file
// never stalls and never applies back-pressure.
interface vregfile_vector_mp_if #(
  parameter int NUMBANKS     = 4,
  parameter int LOG2NUMBANKS = 2,
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 64,
  parameter int LOG2NUMREGS  = 6,
  parameter int NUMRDPORTS   = 3
);
  localparam int AW    = LOG2NUMREGS - LOG2NUMBANKS;
  localparam int NSLOT = NUMRDPORTS * NUMBANKS;
  localparam int NB    = WIDTH / 8;

  logic                      clr;
  logic [NSLOT-1:0]          rd_en;
  logic [NSLOT*AW-1:0]       rd_reg;
  logic [NSLOT*WIDTH-1:0]    rd_data;
  logic [NUMBANKS-1:0]       wr_we;
  logic [NUMBANKS*AW-1:0]    wr_reg;
  logic [NUMBANKS*WIDTH-1:0] wr_data;
  logic [NUMBANKS*NB-1:0]    wr_byteen;

  modport master (
    output clr, rd_en, rd_reg, wr_we, wr_reg, wr_data, wr_byteen,
    input  rd_data
  );

  modport slave (
    input  clr, rd_en, rd_reg, wr_we, wr_reg, wr_data, wr_byteen,
    output rd_data
  );
endinterface

// File: rtl/vregfile_vector_mp.sv
// Banked vector register file with NUMRDPORTS replicated read ports per bank.
// Each register has a valid bit that can be flash-cleared. Unwritten registers
// read as zero. Writes to invalid registers are promoted to full-width writes,
// and the non-enabled bytes are zero-filled.
// Optional feature macro: VREGFILE_MP_BYPASS_EN. When it is defined, a read of
// a register being written in the same cycle returns the merged new word.
// When it is undefined, the read returns the old word.
module vregfile_vector_mp #(
  parameter int NUMBANKS     = 4,
  parameter int LOG2NUMBANKS = 2,
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 64,
  parameter int LOG2NUMREGS  = 6,
  parameter int NUMRDPORTS   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  vregfile_vector_mp_if.slave  bus
);
  localparam int AW    = LOG2NUMREGS - LOG2NUMBANKS;
  localparam int NREGB = NUMREGS / NUMBANKS;
  localparam int NB    = WIDTH / 8;
  localparam int NSLOT = NUMRDPORTS * NUMBANKS;

  // One RAM copy per read port; all copies of a bank receive identical writes.
  logic [WIDTH-1:0] mem_q [NUMBANKS][NUMRDPORTS][NREGB];

  logic [NUMBANKS-1:0][NREGB-1:0] valid_q, valid_d;
  logic [NSLOT-1:0][WIDTH-1:0]    rd_data_q, rd_data_d;

  logic [NSLOT-1:0][AW-1:0]       rd_addr;
  logic [NUMBANKS-1:0][AW-1:0]    wr_addr;
  logic [NUMBANKS-1:0][WIDTH-1:0] wr_wd;
  logic [NUMBANKS-1:0][NB-1:0]    wr_be;
  logic [NUMBANKS-1:0]            wr_act;
  logic [NUMBANKS-1:0]            wr_full;

  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] word;

  assign rd_addr     = bus.rd_reg;
  assign wr_addr     = bus.wr_reg;
  assign wr_wd       = bus.wr_data;
  assign wr_be       = bus.wr_byteen;
  assign bus.rd_data = rd_data_q;

  // Decode each bank's write. A write with no byte enables does nothing.
  // A clr in the same cycle makes the target count as invalid, so it is zero-filled.
  always_comb begin
    wr_act  = '0;
    wr_full = '0;
    for (int k = 0; k < NUMBANKS; k++) begin
      wr_act[k]  = bus.wr_we[k] & (|wr_be[k]);
      wr_full[k] = bus.clr | ~valid_q[k][wr_addr[k]];
    end
  end

  // Next valid state. clr wipes every bit, and a same-cycle write then re-validates its target.
  always_comb begin
    valid_d = bus.clr ? '0 : valid_q;
    for (int k = 0; k < NUMBANKS; k++) begin
      if (wr_act[k]) valid_d[k][wr_addr[k]] = 1'b1;
    end
  end

  // Read path. An enabled slot loads the gated RAM word, and a disabled slot holds its value.
  always_comb begin
    rd_data_d = rd_data_q;
    ra        = '0;
    word      = '0;
    for (int p = 0; p < NUMRDPORTS; p++) begin
      for (int k = 0; k < NUMBANKS; k++) begin
        if (bus.rd_en[p*NUMBANKS+k]) begin
          ra   = rd_addr[p*NUMBANKS+k];
          word = valid_q[k][ra] ? mem_q[k][p][ra] : '0;
`ifdef VREGFILE_MP_BYPASS_EN
          if (wr_act[k] && (wr_addr[k] == ra)) begin
            for (int b = 0; b < NB; b++) begin
              if (wr_be[k][b]) word[b*8 +: 8] = wr_wd[k][b*8 +: 8];
            end
          end
`endif
          rd_data_d[p*NUMBANKS+k] = word;
        end
      end
    end
  end

  // Valid bits and read outputs. Reset clears both and discards any captured read.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      rd_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM copies. Enabled bytes take new data. The other bytes are kept, or are zeroed when the target is invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUMBANKS; k++) begin
        if (wr_act[k]) begin
          for (int p = 0; p < NUMRDPORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
              if (wr_be[k][b])
                mem_q[k][p][wr_addr[k]][b*8 +: 8] <= wr_wd[k][b*8 +: 8];
              else if (wr_full[k])
                mem_q[k][p][wr_addr[k]][b*8 +: 8] <= 8'h00;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vregfile_vector_mp.sv
// Self-checking bench for vregfile_vector_mp with default parameters
// (4 banks, 3 read ports, 32-bit words, 16 registers per bank).
module tb_vregfile_vector_mp;
  localparam int NBK = 4;
  localparam int NP  = 3;
  localparam int NS  = NBK * NP;
  localparam int NR  = 16;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state. A register is a word plus a written-since-clear flag.
  logic [31:0] m_mem   [NBK][NR];
  bit          m_valid [NBK][NR];
  logic [31:0] m_exp   [NS];

  vregfile_vector_mp_if bus ();

  vregfile_vector_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    bus.clr       = 1'b0;
    bus.rd_en     = '0;
    bus.rd_reg    = '0;
    bus.wr_we     = '0;
    bus.wr_reg    = '0;
    bus.wr_data   = '0;
    bus.wr_byteen = '0;
    reset         = 1'b0;
  endtask

  task automatic set_rd(input int p, input int k, input int a);
    logic [3:0] a4;
    a4 = a[3:0];
    bus.rd_en[p*NBK+k]           = 1'b1;
    bus.rd_reg[(p*NBK+k)*4 +: 4] = a4;
  endtask

  task automatic set_wr(input int k, input int a, input logic [31:0] d, input logic [3:0] be);
    logic [3:0] a4;
    a4 = a[3:0];
    bus.wr_we[k]            = 1'b1;
    bus.wr_reg[k*4 +: 4]    = a4;
    bus.wr_data[k*32 +: 32] = d;
    bus.wr_byteen[k*4 +: 4] = be;
  endtask

  // Reference model: apply one clock edge's worth of the register-file rules.
  task automatic model_step();
    logic [31:0] e, d, base;
    logic [3:0]  be;
    int          a;
    bit          wrote [NBK][NR];
    if (reset) begin
      for (int k = 0; k < NBK; k++)
        for (int r = 0; r < NR; r++) m_valid[k][r] = 0;
      for (int s = 0; s < NS; s++) m_exp[s] = '0;
      return;
    end
    for (int k = 0; k < NBK; k++)
      for (int r = 0; r < NR; r++) wrote[k][r] = 0;
    // reads see the state from before this edge
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < NBK; k++) begin
        if (bus.rd_en[p*NBK+k]) begin
          a = int'(bus.rd_reg[(p*NBK+k)*4 +: 4]);
          e = m_valid[k][a] ? m_mem[k][a] : 32'h0;
`ifdef VREGFILE_MP_BYPASS_EN
          be = bus.wr_byteen[k*4 +: 4];
          d  = bus.wr_data[k*32 +: 32];
          if (bus.wr_we[k] && be != 4'h0 && int'(bus.wr_reg[k*4 +: 4]) == a)
            for (int b = 0; b < 4; b++) if (be[b]) e[b*8 +: 8] = d[b*8 +: 8];
`endif
          m_exp[p*NBK+k] = e;
        end
      end
    end
    // writes: the target counts as invalid if it was never written or if clr is active
    for (int k = 0; k < NBK; k++) begin
      be = bus.wr_byteen[k*4 +: 4];
      if (bus.wr_we[k] && be != 4'h0) begin
        a    = int'(bus.wr_reg[k*4 +: 4]);
        d    = bus.wr_data[k*32 +: 32];
        base = (m_valid[k][a] && !bus.clr) ? m_mem[k][a] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) base[b*8 +: 8] = d[b*8 +: 8];
        m_mem[k][a] = base;
        wrote[k][a] = 1;
      end
    end
    for (int k = 0; k < NBK; k++)
      for (int r = 0; r < NR; r++)
        m_valid[k][r] = wrote[k][r] ? 1'b1 : (bus.clr ? 1'b0 : m_valid[k][r]);
  endtask

  // Scoreboard: one edge, then compare every slot against the model.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int s = 0; s < NS; s++)
      check($sformatf("slot%0d", s), bus.rd_data[s*32 +: 32], m_exp[s]);
    idle();
  endtask

  task automatic chk(input string tag, input int p, input int k, input logic [31:0] exp);
    check(tag, bus.rd_data[(p*NBK+k)*32 +: 32], exp);
  endtask

  initial begin
    for (int k = 0; k < NBK; k++)
      for (int r = 0; r < NR; r++) begin
        m_mem[k][r]   = '0;
        m_valid[k][r] = 0;
      end
    for (int s = 0; s < NS; s++) m_exp[s] = '0;

    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b1;
    cycle();
    for (int s = 0; s < NS; s++) check("reset_rd", bus.rd_data[s*32 +: 32], 32'h0);

    // unwritten reg reads zero, then full write
    for (int p = 0; p < NP; p++) set_rd(p, 0, 5);
    cycle();
    for (int p = 0; p < NP; p++) chk("fresh_zero", p, 0, 32'h0);
    set_wr(0, 5, 32'hDEADBEEF, 4'hF);
    cycle();
    for (int p = 0; p < NP; p++) set_rd(p, 0, 5);
    cycle();
    for (int p = 0; p < NP; p++) chk("full_write", p, 0, 32'hDEADBEEF);

    // partial write promotion on a fresh register, then byte merge
    set_wr(2, 9, 32'h11223344, 4'h2);
    cycle();
    set_rd(1, 2, 9);
    cycle();
    chk("promote", 1, 2, 32'h00003300);
    set_wr(2, 9, 32'hAABBCCDD, 4'h8);
    cycle();
    set_rd(1, 2, 9);
    cycle();
    chk("merge", 1, 2, 32'hAA003300);

    // flash clear
    set_wr(3, 3, 32'h12345678, 4'hF);
    cycle();
    bus.clr = 1'b1;
    cycle();
    set_rd(2, 3, 3);
    cycle();
    chk("clr_zero", 2, 3, 32'h0);
    set_wr(3, 3, 32'h000000FF, 4'h1);
    cycle();
    set_rd(2, 3, 3);
    cycle();
    chk("clr_rewrite", 2, 3, 32'h000000FF);

    // read during write on the same register
    set_wr(1, 7, 32'h01020304, 4'hF);
    cycle();
    set_wr(1, 7, 32'hFFFFFFFF, 4'h3);
    set_rd(0, 1, 7);
    cycle();
`ifdef VREGFILE_MP_BYPASS_EN
    chk("rdw_same", 0, 1, 32'h0102FFFF);
`else
    chk("rdw_same", 0, 1, 32'h01020304);
`endif
    set_rd(0, 1, 7);
    cycle();
    chk("rdw_after", 0, 1, 32'h0102FFFF);

    // read hold while the register changes, then reset
    set_wr(0, 1, 32'hCAFE0000, 4'hF);
    cycle();
    set_rd(0, 0, 1);
    cycle();
    chk("hold_load", 0, 0, 32'hCAFE0000);
    for (int i = 0; i < 3; i++) begin
      set_wr(0, 1, 32'h0, 4'hF);
      cycle();
      chk("hold", 0, 0, 32'hCAFE0000);
    end
    reset = 1'b1;
    cycle();
    chk("hold_reset", 0, 0, 32'h0);
    set_rd(0, 0, 1);
    cycle();
    chk("post_reset_rd", 0, 0, 32'h0);

    // random concurrent traffic
    for (int c = 0; c < 10000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      bus.clr = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < NBK; k++)
        if ($urandom_range(0, 1) == 1)
          set_wr(k, $urandom_range(0, 7), $urandom, 4'($urandom_range(0, 15)));
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 2) != 0) set_rd(s / NBK, s % NBK, $urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
